// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the uart_dev peripheral.
//   - Register offsets selected by Addr[3:2] (word address bits [1:0]).
//   - STATUS and CTRL bit positions.
//   - uart_state_t, the state encoding shared by the TX and RX FSMs.
//   - eff_div(): the divisor actually used for timing (0 behaves as 1).
package uart_pkg;

  localparam logic [1:0] UART_TXDATA = 2'd0;
  localparam logic [1:0] UART_RXDATA = 2'd1;
  localparam logic [1:0] UART_STATUS = 2'd2;
  localparam logic [1:0] UART_CTRL   = 2'd3;

  localparam int ST_TXE   = 0;
  localparam int ST_TXF   = 1;
  localparam int ST_RXV   = 2;
  localparam int ST_RXOVR = 3;
  localparam int ST_TXOVR = 4;
  localparam int ST_FERR  = 5;

  localparam int CT_TXIE = 16;
  localparam int CT_RXIE = 17;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular buffer feeding the UART transmitter.
// Ports:
//   clk, reset     clock, asynchronous active-low reset (empties the buffer)
//   push_i/data_i  write request and byte
//   pop_i          read request; ignored while empty
//   data_o         head entry (valid while not empty)
//   accept_o       push_i would be stored this cycle
//   empty_o        no entries
//   count_o        number of entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [W-1:0]           data_i,
  input  logic                   pop_i,
  output logic [W-1:0]           data_o,
  output logic                   accept_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0]   cnt_q;
  logic          full, pop_ok, push_ok;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  // A pop in the same cycle frees a slot, so a full buffer still accepts.
  assign push_ok = push_i && (!full || pop_ok);

  assign accept_o = push_ok;
  assign data_o   = mem_q[rd_ptr_q];
  assign count_o  = cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_dev.sv
// uart_dev: memory-mapped 8N1 UART on the bridge device interface.
// Ports:
//   clk, reset  clock, asynchronous active-low reset
//   Addr        word address; Addr[1:0] (byte address [3:2]) selects register
//   WE, Din     write strobe and data
//   Dout        combinational read data
//   IRQ         registered (TXIE & TXE) | (RXIE & RXV)
//   txd, rxd    serial out (idles high) / serial in (asynchronous)
// Build option: define UART_RX_EN to include the receiver; without it rxd is
// ignored and RXDATA, RXV/RXOVR/FERR and RXIE read as 0.
module uart_dev
  import uart_pkg::*;
#(
  parameter logic [15:0] DEFAULT_DIV = 16'd868,
  parameter int          TX_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ,
  output logic        txd,
  input  logic        rxd
);

  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic [15:0] div_q, div_eff;
  logic        txie_q, txovr_q, irq_q;
  logic        wr_tx, wr_rx, wr_st, wr_ct;
  logic        txe, txf;

  logic        rxie_v, rxv_v, rxovr_v, ferr_v;
  logic [7:0]  rx_hold_v;

  assign div_eff = eff_div(div_q);
  assign wr_tx = WE && (Addr[1:0] == UART_TXDATA);
  assign wr_rx = WE && (Addr[1:0] == UART_RXDATA);
  assign wr_st = WE && (Addr[1:0] == UART_STATUS);
  assign wr_ct = WE && (Addr[1:0] == UART_CTRL);

  // TX FIFO
  logic          tx_pop, fifo_accept, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;

  uart_tx_fifo #(.DEPTH(TX_DEPTH), .W(8)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_i   (wr_tx),
    .data_i   (Din[7:0]),
    .pop_i    (tx_pop),
    .data_o   (fifo_dout),
    .accept_o (fifo_accept),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

  // Count MSB is set only at count == TX_DEPTH (power of two).
  assign txf = fifo_count[CW-1];

  // Transmitter: every state period reloads from the live divisor, so a
  // CTRL write lands on the next bit boundary.
  uart_state_t tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        txd_q, txd_d;

  assign txe = fifo_empty && (tx_state_q == IDLE);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      IDLE: begin
        if (!fifo_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = fifo_dout;
          tx_cnt_d   = div_eff - 16'd1;
          txd_d      = 1'b0;
          tx_state_d = START;
        end
      end
      START: begin
        if (tx_cnt_q == 16'd0) begin
          tx_state_d = DATA;
          tx_cnt_d   = div_eff - 16'd1;
          tx_bit_d   = 3'd0;
          txd_d      = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d = div_eff - 16'd1;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            txd_d      = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (tx_cnt_q == 16'd0) begin
          // Chain straight into the next frame with no idle bit.
          if (!fifo_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = fifo_dout;
            tx_cnt_d   = div_eff - 16'd1;
            txd_d      = 1'b0;
            tx_state_d = START;
          end else begin
            tx_state_d = IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      default: tx_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  assign txd = txd_q;

`ifdef UART_RX_EN
  // Receiver: rx_s2_q is the synchronized line, rx_prev_q its last value.
  uart_state_t rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_half_m1;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d, rx_hold_q;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic        rx_brk_q, rx_brk_d;
  logic        rx_done, rx_ferr;
  logic        rxie_q, rxv_q, rxovr_q, ferr_q;

  assign rx_half_m1 = (div_eff[15:1] == 15'd0) ? 16'd0 : {1'b0, div_eff[15:1]} - 16'd1;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_brk_d   = rx_brk_q;
    rx_done    = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = START;
          rx_cnt_d   = rx_half_m1;
        end
      end
      START: begin
        if (rx_cnt_q == 16'd0) begin
          if (!rx_s2_q) begin
            rx_state_d = DATA;
            rx_cnt_d   = div_eff - 16'd1;
            rx_bit_d   = 3'd0;
          end else begin
            rx_state_d = IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (rx_cnt_q == 16'd0) begin
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_cnt_d   = div_eff - 16'd1;
          if (rx_bit_q == 3'd7) rx_state_d = STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      STOP: begin
        // After a framing error, hold here until the line is released.
        if (rx_brk_q) begin
          if (rx_s2_q) begin
            rx_brk_d   = 1'b0;
            rx_state_d = IDLE;
          end
        end else if (rx_cnt_q == 16'd0) begin
          if (rx_s2_q) begin
            rx_done    = 1'b1;
            rx_state_d = IDLE;
          end else begin
            rx_ferr  = 1'b1;
            rx_brk_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_brk_q   <= 1'b0;
      rx_hold_q  <= '0;
      rxie_q     <= 1'b0;
      rxv_q      <= 1'b0;
      rxovr_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_s1_q    <= rxd;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_brk_q   <= rx_brk_d;
      if (wr_ct) rxie_q <= Din[CT_RXIE];
      // Set beats clear for every flag.
      if (rx_done && !rxv_q) begin
        rx_hold_q <= rx_shift_q;
        rxv_q     <= 1'b1;
      end else if (wr_rx) begin
        rxv_q <= 1'b0;
      end
      if (rx_done && rxv_q)               rxovr_q <= 1'b1;
      else if (wr_st && Din[ST_RXOVR])    rxovr_q <= 1'b0;
      if (rx_ferr)                        ferr_q  <= 1'b1;
      else if (wr_st && Din[ST_FERR])     ferr_q  <= 1'b0;
    end
  end

  assign rxie_v    = rxie_q;
  assign rxv_v     = rxv_q;
  assign rxovr_v   = rxovr_q;
  assign ferr_v    = ferr_q;
  assign rx_hold_v = rx_hold_q;

  logic unused_ok;
  assign unused_ok = ^{Addr[29:2], Din[31:18]};
`else
  assign rxie_v    = 1'b0;
  assign rxv_v     = 1'b0;
  assign rxovr_v   = 1'b0;
  assign ferr_v    = 1'b0;
  assign rx_hold_v = 8'd0;

  logic unused_ok;
  assign unused_ok = ^{Addr[29:2], Din[31:17], rxd};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q   <= DEFAULT_DIV;
      txie_q  <= 1'b0;
      txovr_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      if (wr_ct) begin
        div_q  <= Din[15:0];
        txie_q <= Din[CT_TXIE];
      end
      if (wr_tx && !fifo_accept)       txovr_q <= 1'b1;
      else if (wr_st && Din[ST_TXOVR]) txovr_q <= 1'b0;
      irq_q <= (txie_q & txe) | (rxie_v & rxv_v);
    end
  end

  assign IRQ = irq_q;

  always_comb begin
    Dout = 32'd0;
    case (Addr[1:0])
      UART_TXDATA: Dout = 32'd0;
      UART_RXDATA: Dout = {24'd0, rx_hold_v};
      UART_STATUS: Dout = {26'd0, ferr_v, txovr_q, rxovr_v, rxv_v, txf, txe};
      UART_CTRL:   Dout = {14'd0, rxie_v, txie_q, div_q};
      default:     Dout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_uart_dev.sv
module tb_uart_dev;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [29:0] Addr = '0;
  logic        WE = 1'b0;
  logic [31:0] Din = '0;
  logic [31:0] Dout;
  logic        IRQ;
  logic        txd;
  logic        rxd = 1'b1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  uart_dev #(.DEFAULT_DIV(16'd868), .TX_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WE    (WE),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ),
    .txd   (txd),
    .rxd   (rxd)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    Addr = {28'd0, a};
    Din  = d;
    WE   = 1'b1;
    @(negedge clk);
    WE   = 1'b0;
    Din  = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    Addr = {28'd0, a};
    #1;
    d = Dout;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stopb, input int div);
    @(negedge clk);
    rxd = 1'b0;
    repeat (div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (div) @(negedge clk);
    end
    rxd = stopb;
    repeat (div) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * div) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    rd(2'd2, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL reset_status got=%h exp=%h", v, 32'h1); end
    rd(2'd3, v);
    total++; if (v !== 32'h364) begin bad++; $display("FAIL reset_ctrl got=%h exp=%h", v, 32'h364); end
    rd(2'd1, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL reset_rxdata got=%h exp=%h", v, 32'h0); end
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL reset_txd got=%b exp=1", txd); end
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", IRQ); end
  endtask

  task automatic test_tx_frame();
    int exp_seq [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    logic [31:0] v;
    int w;
    wr(2'd3, 32'd4);
    wr(2'd0, 32'hA5);
    w = 0;
    while (txd !== 1'b0 && w < 4) begin
      @(negedge clk);
      w++;
    end
    total++; if (w < 1 || w > 2) begin bad++; $display("FAIL tx_start_latency got=%0d exp=1..2", w); end
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < 4; c++) begin
        total++;
        if (txd !== exp_seq[i][0]) begin
          bad++; $display("FAIL tx_bit%0d_cyc%0d got=%b exp=%0d", i, c, txd, exp_seq[i]);
        end
        if (i == 5 && c == 0) begin
          rd(2'd2, v);
          total++; if (v !== 32'h0) begin bad++; $display("FAIL tx_busy_status got=%h exp=%h", v, 32'h0); end
        end
        @(negedge clk);
      end
    end
    rd(2'd2, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL tx_done_status got=%h exp=%h", v, 32'h1); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    logic [7:0] by;
    int s, f, b, e;
    wr(2'd3, 32'd2);
    for (int k = 1; k <= 106; k++) begin
      if (k <= 5) begin
        Addr = 30'd0; Din = k; WE = 1'b1;
      end else begin
        WE = 1'b0; Din = '0; Addr = 30'd2;
      end
      @(negedge clk);
      if (k < 2) e = 1;
      else begin
        s = k - 2; f = s / 20; b = (s % 20) / 2;
        by = 8'(f + 1);
        if (f >= 5) e = 1;
        else if (b == 0) e = 0;
        else if (b == 9) e = 1;
        else e = int'(by[b-1]);
      end
      total++;
      if (txd !== e[0]) begin bad++; $display("FAIL b2b_txd cyc=%0d got=%b exp=%0d", k, txd, e); end
      if (k == 6) begin
        #1; v = Dout;
        total++; if (v !== 32'h2) begin bad++; $display("FAIL b2b_full_status got=%h exp=%h", v, 32'h2); end
      end
    end
    rd(2'd2, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL b2b_done_status got=%h exp=%h", v, 32'h1); end
  endtask

  task automatic test_irq();
    logic [31:0] v;
    wr(2'd3, 32'h0001_0004);
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL irq_lag got=%b exp=0", IRQ); end
    @(negedge clk);
    total++; if (IRQ !== 1'b1) begin bad++; $display("FAIL irq_txe got=%b exp=1", IRQ); end
    rd(2'd3, v);
    total++; if (v !== 32'h0001_0004) begin bad++; $display("FAIL irq_ctrl got=%h exp=%h", v, 32'h0001_0004); end
    wr(2'd3, 32'h0003_0004);
    rd(2'd3, v);
`ifdef UART_RX_EN
    total++; if (v !== 32'h0003_0004) begin bad++; $display("FAIL ctrl_rxie got=%h exp=%h", v, 32'h0003_0004); end
`else
    total++; if (v !== 32'h0001_0004) begin bad++; $display("FAIL ctrl_rxie got=%h exp=%h", v, 32'h0001_0004); end
`endif
    wr(2'd3, 32'd4);
    @(negedge clk);
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL irq_off got=%b exp=0", IRQ); end
  endtask

`ifdef UART_RX_EN
  task automatic test_rx();
    logic [31:0] v;
    wr(2'd3, 32'h0002_0008);
    send_rx(8'h3C, 1'b1, 8);
    rd(2'd2, v);
    total++; if (v !== 32'h5) begin bad++; $display("FAIL rx_status got=%h exp=%h", v, 32'h5); end
    rd(2'd1, v);
    total++; if (v !== 32'h3C) begin bad++; $display("FAIL rx_data got=%h exp=%h", v, 32'h3C); end
    total++; if (IRQ !== 1'b1) begin bad++; $display("FAIL rx_irq got=%b exp=1", IRQ); end
    send_rx(8'h55, 1'b1, 8);
    rd(2'd2, v);
    total++; if (v !== 32'hD) begin bad++; $display("FAIL rx_ovr_status got=%h exp=%h", v, 32'hD); end
    rd(2'd1, v);
    total++; if (v !== 32'h3C) begin bad++; $display("FAIL rx_ovr_data got=%h exp=%h", v, 32'h3C); end
    wr(2'd1, 32'd0);
    wr(2'd2, 32'h08);
    rd(2'd2, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL rx_ack_status got=%h exp=%h", v, 32'h1); end
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL rx_ack_irq got=%b exp=0", IRQ); end
    send_rx(8'h3C, 1'b0, 8);
    rd(2'd2, v);
    total++; if (v !== 32'h21) begin bad++; $display("FAIL rx_ferr_status got=%h exp=%h", v, 32'h21); end
    wr(2'd2, 32'h20);
    rd(2'd2, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL rx_ferr_clear got=%h exp=%h", v, 32'h1); end
  endtask
`else
  task automatic test_rx_absent();
    logic [31:0] v;
    wr(2'd3, 32'h0002_0008);
    send_rx(8'h3C, 1'b1, 8);
    send_rx(8'h55, 1'b0, 8);
    rd(2'd2, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL norx_status got=%h exp=%h", v, 32'h1); end
    rd(2'd1, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL norx_rxdata got=%h exp=%h", v, 32'h0); end
    total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL norx_irq got=%b exp=0", IRQ); end
  endtask
`endif

  task automatic test_overflow_reset();
    logic [31:0] v;
    int odd;
    wr(2'd3, 32'd100);
    for (int k = 1; k <= 6; k++) begin
      Addr = 30'd0; Din = k; WE = 1'b1;
      @(negedge clk);
    end
    WE = 1'b0; Din = '0;
    rd(2'd2, v);
    total++; if (v !== 32'h12) begin bad++; $display("FAIL ovr_status got=%h exp=%h", v, 32'h12); end
    wr(2'd2, 32'h10);
    rd(2'd2, v);
    total++; if (v !== 32'h2) begin bad++; $display("FAIL ovr_clear got=%h exp=%h", v, 32'h2); end
    repeat (250) @(negedge clk);
    total++; if (txd !== 1'b0) begin bad++; $display("FAIL mid_data_txd got=%b exp=0", txd); end
    reset = 1'b0;
    #1;
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL async_reset_txd got=%b exp=1", txd); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    rd(2'd2, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL post_reset_status got=%h exp=%h", v, 32'h1); end
    rd(2'd3, v);
    total++; if (v !== 32'h364) begin bad++; $display("FAIL post_reset_ctrl got=%h exp=%h", v, 32'h364); end
    odd = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (txd !== 1'b1) odd++;
    end
    total++; if (odd != 0) begin bad++; $display("FAIL fifo_emptied low_cycles got=%0d exp=0", odd); end
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_back_to_back();
    test_irq();
`ifdef UART_RX_EN
    test_rx();
`else
    test_rx_absent();
`endif
    test_overflow_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_dev.md
# uart_dev

Memory-mapped 8N1 UART peripheral hung off the system bridge as a third device slot beside the two timers, using the same Addr/WE/Din/Dout/IRQ device interface. Its IRQ drives one of the CPU's spare interrupt inputs, the bit above `tc1.IRQ`. The block has a 4-entry TX FIFO with a bit-serial transmitter and a single-byte receive holding register fed by an oversampling-free mid-bit receiver.

## Interface
- `DEFAULT_DIV`, 16'd868: reset value of the divisor (clock cycles per bit).
- `TX_DEPTH`, 4: TX FIFO entries; must be a power of two.
- `clk` input 1: sole clock; all state on the rising edge.
- `reset` input 1: asynchronous, active-low; clears all state immediately.
- `Addr` input 30: word address `[31:2]`; `Addr[3:2]` selects the register; higher bits are already decoded by the bridge.
- `WE` input 1: register write strobe, sampled on the clock edge.
- `Din` input 32: write data.
- `Dout` output 32: read data, combinational from `Addr[3:2]` and state.
- `IRQ` output 1: registered level interrupt.
- `txd` output 1: serial out; idles high.
- `rxd` input 1: serial in, asynchronous to `clk`.

## Operation
Register map, selected by `Addr[3:2]`:
- **0 TXDATA**
  - A write pushes `Din[7:0]`.
  - A write while the FIFO is full is dropped and sets TXOVR.
  - Reads return 0.
- **1 RXDATA**
  - Reads return `{24'b0, rx_hold}`.
  - Any write clears RXV (acknowledge).
- **2 STATUS**, read-only except for the sticky bits:
  - `[0]` TXE: FIFO empty and transmitter idle.
  - `[1]` TXF: FIFO full.
  - `[2]` RXV: receive byte valid.
  - `[3]` RXOVR: receive overrun (sticky).
  - `[4]` TXOVR: transmit overrun (sticky).
  - `[5]` FERR: framing error (sticky).
  - A write with 1 in any of bits `[5:3]` clears that bit.
- **3 CTRL**
  - `[15:0]` DIV.
  - `[16]` TXIE.
  - `[17]` RXIE.
  - Reset value is `{14'b0, 2'b00, DEFAULT_DIV}`.

Reads have no side effects.

Transmitter FSM: IDLE → START → DATA → STOP → IDLE.
- In IDLE, with the FIFO non-empty, pop the head into the shifter and enter START.
- Each state lasts DIV cycles. A DIV of 0 is treated as 1.
- START drives 0. DATA drives 8 bits LSB first. STOP drives 1.
- At the end of STOP, if the FIFO is non-empty, go straight to START with the next byte; there is no extra idle bit.
- A CTRL write mid-frame takes effect on the next bit period.

Receiver FSM: IDLE → START → DATA → STOP.
- `rxd` passes through a 2-FF synchronizer before use.
- A falling edge in IDLE enters START and waits DIV/2 cycles.
  - If the line is still 0, a DIV counter runs to sample each of the 8 data bits mid-bit.
  - If the line has returned to 1, the edge was a glitch and the FSM goes back to IDLE.
- At the mid-stop sample:
  - If the stop bit is 1 and RXV = 0: load `rx_hold` and set RXV.
  - If the stop bit is 1 and RXV = 1: drop the byte and set RXOVR.
  - If the stop bit is 0: drop the byte, set FERR, and return to IDLE only after the line reads 1.

IRQ is registered: `(TXIE & TXE) | (RXIE & RXV)`.

Boundary conditions:
- A push and a pop in the same cycle on a full FIFO: the pop frees a slot and the push is accepted.
- A push and a pop in the same cycle on an empty FIFO cannot happen, because the pop requires a non-empty FIFO.
- An RXDATA acknowledge in the same cycle RXV is set by a new byte: the new byte wins and RXV stays 1.
- A sticky-clear in the same cycle the bit is set: the set wins.
- Reset mid-frame: `txd` goes to 1 immediately, both FSMs go to IDLE, and the FIFO is emptied.

## Timing
- Write latency: a TXDATA write at edge N makes the FIFO non-empty after edge N. START begins at edge N+1, so `txd` falls within 2 cycles of the write.
- One frame is 10×DIV cycles.
- `Dout` is combinational, valid in the same cycle as `Addr`.
- IRQ follows its source by 1 cycle.
- RXV is set 2 (synchronizer) + 9.5×DIV cycles after the start-bit falling edge on `rxd`.
- Reset values:
  - `txd` = 1.
  - IRQ = 0.
  - All STATUS bits 0, except TXE = 1.
  - `rx_hold` = 0.

## Configuration
- `UART_RX_EN` defined: the receiver, synchronizer, RXDATA, RXV/RXOVR/FERR and RXIE are built as described.
- `UART_RX_EN` undefined:
  - The receiver logic is absent and `rxd` is ignored.
  - RXDATA reads 0, and STATUS bits `[3:2]` and `[5]` read 0.
  - The RXIE bit is not stored and reads 0.
  - The RX term of IRQ is 0.

## Structure
- Shared package `uart_pkg`:
  - Register offset constants (`UART_TXDATA`..`UART_CTRL`).
  - STATUS and CTRL bit-index constants.
  - The `uart_state_t` enum (IDLE/START/DATA/STOP), used by both FSMs.
- Sub-module `uart_tx_fifo`: parameterized circular buffer with push/pop/full/empty and a count of width `$clog2(TX_DEPTH)+1`.
- Both FSMs stay inline in `uart_dev`.

## Test plan
- Reset, then read STATUS → `0x00000001`; CTRL → `0x00000364`; `txd` = 1.
- DIV = 4; write TXDATA `0xA5` → `txd` sequence 0,1,0,1,0,0,1,0,1,1, each level for 4 cycles; TXE returns to 1 at frame end.
- DIV = 2; 5 back-to-back TXDATA writes `0x01`..`0x05` → the FIFO takes 4, TXF is set; either `0x05` is dropped with TXOVR = 1, or, if a pop occurred, it is accepted. Check against the model. Frames are contiguous with no idle gap.
- DIV = 8; drive byte `0x3C` on `rxd` → RXV = 1 and RXDATA = `0x3C`; with RXIE = 1, IRQ = 1 one cycle later. A second byte `0x55` before the ack → RXOVR = 1 and RXDATA is still `0x3C`.
- Drive a frame with stop bit 0 → FERR = 1 and RXV unchanged; write STATUS `0x20` → FERR = 0.
- Assert `reset` mid-DATA bit → `txd` = 1 immediately; after release, STATUS = `0x00000001` and the FIFO is empty.
